// File: rtl/instr_prefetch_pkg.sv
// Shared definitions for the instruction prefetch unit: fetch FSM encoding,
// data widths, the FIFO entry layout and a word-alignment helper.
package instr_prefetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Force a byte address onto a 32-bit word boundary.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Prefetch FIFO: array storage written at the tail, plus a registered head
// copy so out_pc/out_instr come straight from flops. Full/empty from a count.
module prefetch_fifo
    import instr_prefetch_pkg::*;
#(
    parameter int DEPTH_BITWIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  fetch_entry_t            push_entry,
    input  logic                    pop,
    output logic                    head_valid,
    output fetch_entry_t            head_entry,
    output logic [DEPTH_BITWIDTH:0] count
);

    localparam int DEPTH = 2 ** DEPTH_BITWIDTH;

    fetch_entry_t                store [DEPTH];
    logic [DEPTH_BITWIDTH-1:0]   wr_ptr_reg;
    logic [DEPTH_BITWIDTH-1:0]   rd_ptr_reg;
    logic [DEPTH_BITWIDTH-1:0]   rd_ptr_inc;
    logic [DEPTH_BITWIDTH:0]     count_reg;
    fetch_entry_t                head_reg;
    logic                        do_push;
    logic                        do_pop;

    // A flush wins over both a push and a pop in the same cycle.
    assign do_push    = push && !flush;
    assign do_pop     = pop && (count_reg != '0) && !flush;
    assign rd_ptr_inc = rd_ptr_reg + DEPTH_BITWIDTH'(1);

    assign head_valid = (count_reg != '0);
    assign head_entry = head_reg;
    assign count      = count_reg;

    // Tail write into the storage array (no reset, plain RAM).
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr_reg] <= push_entry;
        end
    end

    // Pointers, occupancy and head register. The head is loaded from the push
    // data when the entry becomes the oldest one, otherwise from the array
    // slot behind the entry being popped.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + DEPTH_BITWIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (DEPTH_BITWIDTH+1)'(1);
                2'b01:   count_reg <= count_reg - (DEPTH_BITWIDTH+1)'(1);
                default: count_reg <= count_reg;
            endcase
            if (do_push && ((count_reg == '0) ||
                            ((count_reg == (DEPTH_BITWIDTH+1)'(1)) && do_pop))) begin
                head_reg <= push_entry;
            end else if (do_pop && (count_reg > (DEPTH_BITWIDTH+1)'(1))) begin
                head_reg <= store[rd_ptr_inc];
            end
        end
    end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch unit: keeps one request in flight to the instruction
// memory, queues returned words with their PC, and flushes on redirect.
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int          DEPTH_BITWIDTH = 2,
    parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    input  logic        mem_valid,
    input  logic        mem_bsy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int                    DEPTH     = 2 ** DEPTH_BITWIDTH;
    localparam logic [DEPTH_BITWIDTH:0]   DEPTH_CNT = (DEPTH_BITWIDTH+1)'(DEPTH);
    localparam logic [DEPTH_BITWIDTH+1:0] DEPTH_EXT = (DEPTH_BITWIDTH+2)'(DEPTH);

    fetch_state_t              state_reg;
    fetch_state_t              state_next;
    logic [ADDR_W-1:0]         fetch_pc_reg;
    logic [ADDR_W-1:0]         fetch_pc_next;
    logic                      accept;
    logic                      push;
    logic                      pop;
    logic [DEPTH_BITWIDTH:0]   fifo_count;
    logic [DEPTH_BITWIDTH+1:0] occ_after;
    fetch_entry_t              push_entry;
    fetch_entry_t              head_entry;

    assign accept     = (state_reg == REQ) && !mem_bsy;
    assign pop        = out_valid && out_ready && !redirect;
    assign push_entry = '{pc: fetch_pc_reg, instr: mem_dout};

    // Occupancy once this cycle's response is pushed and any pop is taken.
    assign occ_after  = {1'b0, fifo_count} + (DEPTH_BITWIDTH+2)'(1)
                        - (DEPTH_BITWIDTH+2)'(pop);

    assign mem_en    = (state_reg == REQ);
    assign mem_addr  = mem_en ? fetch_pc_reg : '0;
    assign out_instr = head_entry.instr;
    assign out_pc    = head_entry.pc;

    // Fetch state and fetch PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= word_align(RESET_PC);
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
        end
    end

    // Next-state, fetch PC and push decision; a redirect overrides all of it.
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        push          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fifo_count < DEPTH_CNT) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (accept) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_valid) begin
                    push          = 1'b1;
                    fetch_pc_next = fetch_pc_reg + 32'd4;
                    state_next    = (occ_after < DEPTH_EXT) ? REQ : IDLE;
                end
            end
            DISCARD: begin
                if (mem_valid) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase

        if (redirect) begin
            push          = 1'b0;
            fetch_pc_next = word_align(redirect_pc);
            case (state_reg)
                REQ:     state_next = accept ? DISCARD : REQ;
                WAIT:    state_next = mem_valid ? REQ : DISCARD;
                // A stale response landing in the same cycle closes the
                // outstanding request, so there is nothing left to discard.
                DISCARD: state_next = mem_valid ? REQ : DISCARD;
                default: state_next = REQ;
            endcase
        end
    end

    prefetch_fifo #(
        .DEPTH_BITWIDTH(DEPTH_BITWIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_valid (out_valid),
        .head_entry (head_entry),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: memory responder with programmable latency and
// busy, an in-order PC/instruction scoreboard, directed corner sequences, a
// table of redirect vectors and a randomized run.
module tb_instr_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout = '0;
    logic        mem_valid = 1'b0;
    logic        mem_bsy = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    always #5 clk = ~clk;

    instr_prefetch #(
        .DEPTH_BITWIDTH(2),
        .RESET_PC      (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .mem_valid  (mem_valid),
        .mem_bsy    (mem_bsy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Knobs applied by step() at the next falling edge.
    bit          k_rst = 1'b1;
    bit          k_ready = 1'b0;
    bit          k_bsy = 1'b0;
    bit          k_redir = 1'b0;
    logic [31:0] k_redir_pc = '0;
    int          k_lat = 0;

    // Memory model and scoreboard state.
    bit          pend = 1'b0;
    int          pend_lat = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] exp_pc = '0;
    int          nacc = 0;
    int          npop = 0;
    logic [31:0] acc_q[$];
    logic [31:0] pop_q[$];
    bit          hold_prev = 1'b0;
    logic [31:0] hold_pc = '0;
    logic [31:0] hold_instr = '0;

    typedef struct {
        logic [31:0] pc;
        int          lat;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } redir_vec_t;

    redir_vec_t vecs[4];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, run the memory model
    // and scoreboard, then drive the inputs for the next rising edge.
    task automatic step();
        bit outstanding;
        @(negedge clk);
        if (hold_prev) begin
            chk("head_hold_valid", 32'(out_valid), 32'd1);
            chk("head_hold_pc", out_pc, hold_pc);
            chk("head_hold_instr", out_instr, hold_instr);
        end
        outstanding = pend;
        mem_valid   = 1'b0;
        if (pend) begin
            if (pend_lat == 0) begin
                mem_valid = 1'b1;
                mem_dout  = mem_word(pend_addr);
                pend      = 1'b0;
            end else begin
                pend_lat--;
            end
        end
        rst         = k_rst;
        mem_bsy     = k_bsy;
        out_ready   = k_ready;
        redirect    = k_redir;
        redirect_pc = k_redir_pc;
        if (k_rst) begin
            pend      = 1'b0;
            mem_valid = 1'b0;
            exp_pc    = 32'h0;
            hold_prev = 1'b0;
            acc_q.delete();
            pop_q.delete();
        end else begin
            chk("one_outstanding", 32'(mem_en && outstanding), 32'd0);
            chk("addr_align", mem_addr & 32'h3, 32'h0);
            if (mem_en && !k_bsy) begin
                pend      = 1'b1;
                pend_lat  = k_lat;
                pend_addr = mem_addr;
                acc_q.push_back(mem_addr);
                nacc++;
            end
            if (k_redir) begin
                exp_pc    = k_redir_pc & ~32'h3;
                hold_prev = 1'b0;
                acc_q.delete();
                pop_q.delete();
            end else if (out_valid && k_ready) begin
                chk("pop_pc", out_pc, exp_pc);
                chk("pop_instr", out_instr, mem_word(exp_pc));
                pop_q.push_back(out_pc);
                exp_pc += 32'd4;
                npop++;
                hold_prev = 1'b0;
            end else if (out_valid) begin
                hold_prev  = 1'b1;
                hold_pc    = out_pc;
                hold_instr = out_instr;
            end else begin
                hold_prev = 1'b0;
            end
        end
        k_redir = 1'b0;
    endtask

    task automatic do_reset();
        k_rst   = 1'b1;
        k_redir = 1'b0;
        repeat (3) step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        k_rst = 1'b0;
        step();
        nacc = 0;
        npop = 0;
    endtask

    task automatic run_until_pops(input int n, input int budget);
        for (int i = 0; i < budget && pop_q.size() < n; i++) step();
        chk("pop_count_reached", 32'(pop_q.size() >= n), 32'd1);
    endtask

    task automatic run_until_accs(input int n, input int budget);
        for (int i = 0; i < budget && acc_q.size() < n; i++) step();
        chk("acc_count_reached", 32'(acc_q.size() >= n), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0103, 0, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
        vecs[1] = '{32'hFFFF_FFF8, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[2] = '{32'h0000_2007, 2, 32'h0000_2004, 32'h0000_2008, 32'h0000_200C};
        vecs[3] = '{32'hFFFF_FFFE, 0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

        // Reset, first request timing, push latency, in-order stream.
        k_ready = 1'b1; k_bsy = 1'b0; k_lat = 0;
        do_reset();
        step();
        chk("first_req_en", 32'(mem_en), 32'd1);
        chk("first_req_addr", mem_addr, 32'h0);
        for (int i = 0; i < 10 && !mem_valid; i++) step();
        chk("resp_seen", 32'(mem_valid), 32'd1);
        step();
        chk("push_latency", 32'(out_valid), 32'd1);
        run_until_pops(4, 40);
        for (int i = 0; i < 4; i++)
            chk("stream_pc", (i < pop_q.size()) ? pop_q[i] : 32'hxxxx_xxxx, 32'(4 * i));
        $display("seq stream: %0d pops", pop_q.size());

        // Consumer stalled: exactly DEPTH requests, then resume at 0x10.
        k_ready = 1'b0;
        do_reset();
        repeat (40) step();
        chk("stall_accepts", 32'(nacc), 32'd4);
        chk("stall_mem_en", 32'(mem_en), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        k_ready = 1'b1;
        run_until_pops(4, 60);
        run_until_accs(5, 60);
        chk("resume_addr", (acc_q.size() > 4) ? acc_q[4] : 32'hxxxx_xxxx, 32'h10);
        $display("seq stall: %0d accepts before release", 4);

        // Redirect while waiting: stale response dropped.
        k_lat = 3;
        do_reset();
        run_until_pops(2, 60);
        for (int i = 0; i < 30 && !(pend && pend_lat == 3); i++) step();
        chk("wait_reached", 32'(pend && pend_lat == 3), 32'd1);
        k_redir = 1'b1; k_redir_pc = 32'h0000_0103;
        step();
        step();
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        run_until_pops(1, 60);
        chk("redir_wait_pc", (pop_q.size() > 0) ? pop_q[0] : 32'hxxxx_xxxx, 32'h100);
        chk("redir_wait_acc", (acc_q.size() > 0) ? acc_q[0] : 32'hxxxx_xxxx, 32'h100);
        $display("seq redirect-in-wait: next pc 0x100");

        // Response and redirect in the same cycle.
        k_ready = 1'b0; k_lat = 1;
        do_reset();
        for (int i = 0; i < 20 && !(pend && pend_lat == 0); i++) step();
        chk("resp_next_cycle", 32'(pend && pend_lat == 0), 32'd1);
        k_redir = 1'b1; k_redir_pc = 32'h0000_0040;
        step();
        chk("same_cycle_resp", 32'(mem_valid), 32'd1);
        step();
        chk("same_cycle_drop", 32'(out_valid), 32'd0);
        run_until_accs(1, 20);
        chk("same_cycle_next_addr", (acc_q.size() > 0) ? acc_q[0] : 32'hxxxx_xxxx, 32'h40);
        $display("seq redirect-with-valid: next request 0x40");

        // Busy memory: address held, one request accepted.
        k_ready = 1'b1; k_bsy = 1'b1; k_lat = 5;
        do_reset();
        for (int i = 0; i < 10 && !mem_en; i++) step();
        begin
            logic [31:0] held;
            held = mem_addr;
            for (int i = 0; i < 5; i++) begin
                step();
                chk("bsy_mem_en", 32'(mem_en), 32'd1);
                chk("bsy_mem_addr", mem_addr, held);
            end
            chk("bsy_no_accept", 32'(nacc), 32'd0);
            k_bsy = 1'b0;
            step();
            step();
            chk("bsy_one_accept", 32'(nacc), 32'd1);
            chk("bsy_en_dropped", 32'(mem_en), 32'd0);
            chk("bsy_acc_addr", (acc_q.size() > 0) ? acc_q[0] : 32'hxxxx_xxxx, held);
        end
        $display("seq busy: %0d accepted", nacc);

        // Table of redirect targets, including alignment and wrap-around.
        k_ready = 1'b1; k_bsy = 1'b0;
        do_reset();
        foreach (vecs[v]) begin
            k_lat = vecs[v].lat;
            repeat ($urandom_range(0, 6)) step();
            k_redir = 1'b1; k_redir_pc = vecs[v].pc;
            step();
            run_until_pops(3, 100);
            chk("vec_pc0", (pop_q.size() > 0) ? pop_q[0] : 32'hxxxx_xxxx, vecs[v].exp0);
            chk("vec_pc1", (pop_q.size() > 1) ? pop_q[1] : 32'hxxxx_xxxx, vecs[v].exp1);
            chk("vec_pc2", (pop_q.size() > 2) ? pop_q[2] : 32'hxxxx_xxxx, vecs[v].exp2);
            $display("vec %0d: redirect 0x%08h lat %0d", v, vecs[v].pc, vecs[v].lat);
        end

        // Randomized traffic against the scoreboard.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            k_ready = ($urandom % 4) != 0;
            k_bsy   = ($urandom % 3) == 0;
            k_lat   = $urandom_range(0, 3);
            if (($urandom % 40) == 0) begin
                k_redir    = 1'b1;
                k_redir_pc = $urandom;
            end
            step();
        end
        chk("random_progress", 32'(npop > 200), 32'd1);
        $display("random: %0d pops, %0d accepts", npop, nacc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
